// File: rtl/frame_stat_pkg.sv
// Shared types and helpers for the multi-port frame statistics block.
// Holds the per-port FSM encoding and the counter increment rule.
package frame_stat_pkg;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_BUSY = 1'b1
  } frame_state_e;

  localparam int DEF_CNT_W = 16;
  localparam int MAX_CNT_W = 64;

  // Callers zero-extend into MAX_CNT_W and truncate the result back to their width.
  function automatic logic [MAX_CNT_W-1:0] cnt_inc(
    input logic [MAX_CNT_W-1:0] val,
    input logic [MAX_CNT_W-1:0] max_val,
    input logic                 sat
  );
    if (val == max_val) begin
      return sat ? max_val : '0;
    end
    return val + MAX_CNT_W'(1);
  endfunction

endpackage

// File: rtl/frame_stat_chan.sv
// One monitored stream: SOP/EOP framing FSM plus good-frame and error counters.
// Also emits a single-cycle error pulse for the global sticky flag.
module frame_stat_chan
  import frame_stat_pkg::*;
#(
  parameter int CNT_W    = DEF_CNT_W,
  parameter bit SATURATE = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             i_sop,
  input  logic             i_eop,
  input  logic             i_clr,
  output logic             o_in_frame,
  output logic [CNT_W-1:0] o_frame_cnt,
  output logic [CNT_W-1:0] o_err_cnt,
  output logic             o_err_pulse
);

  frame_state_e     state_q, state_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic [CNT_W-1:0] err_cnt_q, err_cnt_d;
  logic             inc_frame, inc_err;

  always_comb begin
    state_d   = state_q;
    inc_frame = 1'b0;
    inc_err   = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (i_sop && !i_eop) begin
          state_d = ST_BUSY;
        end else if (i_sop && i_eop) begin
          inc_frame = 1'b1;
        end else if (i_eop) begin
          inc_err = 1'b1;
        end
      end
      ST_BUSY: begin
        // A new SOP while busy drops the open frame; with EOP it is also a complete frame.
        if (i_eop && !i_sop) begin
          inc_frame = 1'b1;
          state_d   = ST_IDLE;
        end else if (i_sop && !i_eop) begin
          inc_err = 1'b1;
        end else if (i_sop && i_eop) begin
          inc_err   = 1'b1;
          inc_frame = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    frame_cnt_d = frame_cnt_q;
    err_cnt_d   = err_cnt_q;
    if (i_clr) begin
      frame_cnt_d = '0;
      err_cnt_d   = '0;
    end else begin
      if (inc_frame) begin
        frame_cnt_d = CNT_W'(cnt_inc(MAX_CNT_W'(frame_cnt_q),
                                     MAX_CNT_W'({CNT_W{1'b1}}), SATURATE));
      end
      if (inc_err) begin
        err_cnt_d = CNT_W'(cnt_inc(MAX_CNT_W'(err_cnt_q),
                                   MAX_CNT_W'({CNT_W{1'b1}}), SATURATE));
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      frame_cnt_q <= '0;
      err_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      frame_cnt_q <= frame_cnt_d;
      err_cnt_q   <= err_cnt_d;
    end
  end

  assign o_in_frame  = (state_q == ST_BUSY);
  assign o_frame_cnt = frame_cnt_q;
  assign o_err_cnt   = err_cnt_q;
  assign o_err_pulse = inc_err;

endmodule

// File: rtl/multi_port_frame_stat.sv
// Per-port frame statistics for all ingress streams, with a registered
// indexed readback and a sticky any-port error flag.
module multi_port_frame_stat
  import frame_stat_pkg::*;
#(
  parameter int NUM_PORTS = 16,
  parameter int CNT_W     = DEF_CNT_W,
  parameter bit SATURATE  = 1'b0,
  localparam int PORT_W   = (NUM_PORTS > 1) ? $clog2(NUM_PORTS) : 1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_PORTS-1:0] i_sop,
  input  logic [NUM_PORTS-1:0] i_eop,
  input  logic                 i_clr,
  input  logic [PORT_W-1:0]    i_rd_sel,
  output logic [NUM_PORTS-1:0] o_in_frame,
  output logic [CNT_W-1:0]     o_frame_cnt,
  output logic [CNT_W-1:0]     o_err_cnt,
  output logic                 o_err_any
);

  logic [CNT_W-1:0]     frame_cnt [NUM_PORTS];
  logic [CNT_W-1:0]     err_cnt   [NUM_PORTS];
  logic [NUM_PORTS-1:0] err_pulse;

  logic [CNT_W-1:0] rd_frame_q, rd_frame_d;
  logic [CNT_W-1:0] rd_err_q, rd_err_d;
  logic             err_any_q, err_any_d;

  for (genvar p = 0; p < NUM_PORTS; p++) begin : g_chan
    frame_stat_chan #(
      .CNT_W    (CNT_W),
      .SATURATE (SATURATE)
    ) u_chan (
      .clk         (clk),
      .rst_n       (rst_n),
      .i_sop       (i_sop[p]),
      .i_eop       (i_eop[p]),
      .i_clr       (i_clr),
      .o_in_frame  (o_in_frame[p]),
      .o_frame_cnt (frame_cnt[p]),
      .o_err_cnt   (err_cnt[p]),
      .o_err_pulse (err_pulse[p])
    );
  end

  // Out-of-range selects match no port and therefore read back zero.
  always_comb begin
    rd_frame_d = '0;
    rd_err_d   = '0;
    for (int p = 0; p < NUM_PORTS; p++) begin
      if (i_rd_sel == PORT_W'(p)) begin
        rd_frame_d = frame_cnt[p];
        rd_err_d   = err_cnt[p];
      end
    end
  end

  always_comb begin
    err_any_d = i_clr ? 1'b0 : (err_any_q | (|err_pulse));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_frame_q <= '0;
      rd_err_q   <= '0;
      err_any_q  <= 1'b0;
    end else begin
      rd_frame_q <= rd_frame_d;
      rd_err_q   <= rd_err_d;
      err_any_q  <= err_any_d;
    end
  end

  assign o_frame_cnt = rd_frame_q;
  assign o_err_cnt   = rd_err_q;
  assign o_err_any   = err_any_q;

endmodule

// File: tb/tb_multi_port_frame_stat.sv
// Directed bench for multi_port_frame_stat: default, narrow wrap/saturate and
// 12-port instances driven from shared stimulus with hand-computed expectations.
module tb_multi_port_frame_stat;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] sop = '0;
  logic [15:0] eop = '0;
  logic        clr = 1'b0;
  logic [3:0]  rd_sel = '0;
  logic [3:0]  rd_sel12 = '0;

  logic [15:0] in_frame;
  logic [15:0] frame_cnt, err_cnt;
  logic        err_any;
  logic [15:0] in_frame_w, in_frame_s;
  logic [3:0]  frame_cnt_w, err_cnt_w, frame_cnt_s, err_cnt_s;
  logic        err_any_w, err_any_s;
  logic [11:0] in_frame_n;
  logic [15:0] frame_cnt_n, err_cnt_n;
  logic        err_any_n;

  int n_checks = 0;
  int n_errors = 0;

  always #5 clk = ~clk;

  multi_port_frame_stat #(.NUM_PORTS(16), .CNT_W(16), .SATURATE(1'b0)) dut (
    .clk(clk), .rst_n(rst_n), .i_sop(sop), .i_eop(eop), .i_clr(clr), .i_rd_sel(rd_sel),
    .o_in_frame(in_frame), .o_frame_cnt(frame_cnt), .o_err_cnt(err_cnt), .o_err_any(err_any));

  multi_port_frame_stat #(.NUM_PORTS(16), .CNT_W(4), .SATURATE(1'b0)) dut_wrap (
    .clk(clk), .rst_n(rst_n), .i_sop(sop), .i_eop(eop), .i_clr(clr), .i_rd_sel(rd_sel),
    .o_in_frame(in_frame_w), .o_frame_cnt(frame_cnt_w), .o_err_cnt(err_cnt_w), .o_err_any(err_any_w));

  multi_port_frame_stat #(.NUM_PORTS(16), .CNT_W(4), .SATURATE(1'b1)) dut_sat (
    .clk(clk), .rst_n(rst_n), .i_sop(sop), .i_eop(eop), .i_clr(clr), .i_rd_sel(rd_sel),
    .o_in_frame(in_frame_s), .o_frame_cnt(frame_cnt_s), .o_err_cnt(err_cnt_s), .o_err_any(err_any_s));

  multi_port_frame_stat #(.NUM_PORTS(12), .CNT_W(16), .SATURATE(1'b0)) dut_n12 (
    .clk(clk), .rst_n(rst_n), .i_sop(sop[11:0]), .i_eop(eop[11:0]), .i_clr(clr), .i_rd_sel(rd_sel12),
    .o_in_frame(in_frame_n), .o_frame_cnt(frame_cnt_n), .o_err_cnt(err_cnt_n), .o_err_any(err_any_n));

  task automatic applyStimulus(input logic [15:0] s, input logic [15:0] e, input logic c);
    sop = s;
    eop = e;
    clr = c;
    @(posedge clk);
    #1;
    sop = '0;
    eop = '0;
    clr = 1'b0;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    n_checks++;
    assert (observed === expected) else begin
      n_errors++;
      $error("[TB] FAIL %s: observed %0d expected %0d", tag, observed, expected);
    end
  endtask

  initial begin
    // Reset state of every instance
    #3;
    checkOutput("rst_in_frame", 32'(in_frame), 32'd0);
    checkOutput("rst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("rst_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("rst_err_any", 32'(err_any), 32'd0);
    checkOutput("rst_wrap_any", 32'({err_any_w, in_frame_w, frame_cnt_w, err_cnt_w}), 32'd0);
    checkOutput("rst_sat_any", 32'({err_any_s, in_frame_s, frame_cnt_s, err_cnt_s}), 32'd0);
    checkOutput("rst_n12_any", 32'({err_any_n, in_frame_n}), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Port 0: three back-to-back four-cycle frames
    rd_sel = 4'd0;
    for (int f = 0; f < 3; f++) begin
      applyStimulus(16'h0001, 16'h0000, 1'b0);
      checkOutput("p0_in_frame_c1", 32'(in_frame[0]), 32'd1);
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      checkOutput("p0_in_frame_c2", 32'(in_frame[0]), 32'd1);
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      checkOutput("p0_in_frame_c3", 32'(in_frame[0]), 32'd1);
      applyStimulus(16'h0000, 16'h0001, 1'b0);
      checkOutput("p0_in_frame_end", 32'(in_frame[0]), 32'd0);
    end
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    checkOutput("p0_frame_cnt", 32'(frame_cnt), 32'd3);
    checkOutput("p0_err_cnt", 32'(err_cnt), 32'd0);
    checkOutput("p0_err_any", 32'(err_any), 32'd0);

    // Port 5: single-cycle frame then orphan EOP
    applyStimulus(16'h0020, 16'h0020, 1'b0);
    checkOutput("p5_in_frame_single", 32'(in_frame[5]), 32'd0);
    applyStimulus(16'h0000, 16'h0020, 1'b0);
    checkOutput("p5_in_frame_orphan", 32'(in_frame[5]), 32'd0);
    checkOutput("p5_err_any", 32'(err_any), 32'd1);
    rd_sel = 4'd5;
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    checkOutput("p5_frame_cnt", 32'(frame_cnt), 32'd1);
    checkOutput("p5_err_cnt", 32'(err_cnt), 32'd1);

    // Clear zeroes counters and the sticky flag
    applyStimulus(16'h0000, 16'h0000, 1'b1);
    checkOutput("clr_err_any", 32'(err_any), 32'd0);
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    checkOutput("clr_p5_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("clr_p5_err_cnt", 32'(err_cnt), 32'd0);

    // All ports: SOP, SOP, EOP -> one error and one good frame each
    applyStimulus(16'hFFFF, 16'h0000, 1'b0);
    checkOutput("all_in_frame_busy", 32'(in_frame), 32'h0000_FFFF);
    applyStimulus(16'hFFFF, 16'h0000, 1'b0);
    checkOutput("all_err_any", 32'(err_any), 32'd1);
    applyStimulus(16'h0000, 16'hFFFF, 1'b0);
    checkOutput("all_in_frame_idle", 32'(in_frame), 32'd0);
    for (int p = 0; p < 16; p++) begin
      rd_sel = 4'(p);
      applyStimulus(16'h0000, 16'h0000, 1'b0);
      checkOutput($sformatf("all_p%0d_frame_cnt", p), 32'(frame_cnt), 32'd1);
      checkOutput($sformatf("all_p%0d_err_cnt", p), 32'(err_cnt), 32'd1);
    end

    // Port 6: 17 single-cycle frames for wrap and saturation
    applyStimulus(16'h0000, 16'h0000, 1'b1);
    for (int i = 0; i < 17; i++) begin
      applyStimulus(16'h0040, 16'h0040, 1'b0);
    end
    rd_sel = 4'd6;
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    checkOutput("p6_frame_cnt_w16", 32'(frame_cnt), 32'd17);
    checkOutput("p6_frame_cnt_wrap", 32'(frame_cnt_w), 32'd1);
    checkOutput("p6_frame_cnt_sat", 32'(frame_cnt_s), 32'd15);
    checkOutput("p6_err_cnt_sat", 32'(err_cnt_s), 32'd0);

    // Port 1: clear on the 2nd EOP, then a 3rd frame spanning another clear
    applyStimulus(16'h0000, 16'h0000, 1'b1);
    rd_sel = 4'd1;
    applyStimulus(16'h0002, 16'h0000, 1'b0);
    applyStimulus(16'h0000, 16'h0002, 1'b0);
    applyStimulus(16'h0002, 16'h0000, 1'b0);
    checkOutput("p1_one_frame", 32'(frame_cnt), 32'd1);
    applyStimulus(16'h0000, 16'h0002, 1'b1);
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    checkOutput("p1_clr_wins", 32'(frame_cnt), 32'd0);
    applyStimulus(16'h0002, 16'h0000, 1'b0);
    checkOutput("p1_in_frame_3rd", 32'(in_frame[1]), 32'd1);
    applyStimulus(16'h0000, 16'h0000, 1'b1);
    checkOutput("p1_in_frame_after_clr", 32'(in_frame[1]), 32'd1);
    applyStimulus(16'h0000, 16'h0002, 1'b0);
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    checkOutput("p1_frame_after_clr", 32'(frame_cnt), 32'd1);
    checkOutput("p1_err_after_clr", 32'(err_cnt), 32'd0);
    checkOutput("p1_err_any_after_clr", 32'(err_any), 32'd0);

    // Asynchronous reset in the middle of a port 3 frame
    applyStimulus(16'h0000, 16'h0010, 1'b0);
    checkOutput("p4_orphan_err_any", 32'(err_any), 32'd1);
    applyStimulus(16'h0008, 16'h0000, 1'b0);
    checkOutput("p3_in_frame_pre_rst", 32'(in_frame[3]), 32'd1);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("arst_in_frame", 32'(in_frame), 32'd0);
    checkOutput("arst_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("arst_err_any", 32'(err_any), 32'd0);
    checkOutput("arst_n12_in_frame", 32'(in_frame_n), 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    applyStimulus(16'h0000, 16'h0008, 1'b0);
    checkOutput("p3_in_frame_post_rst", 32'(in_frame[3]), 32'd0);
    rd_sel = 4'd3;
    rd_sel12 = 4'd3;
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    checkOutput("p3_err_cnt", 32'(err_cnt), 32'd1);
    checkOutput("p3_frame_cnt", 32'(frame_cnt), 32'd0);
    checkOutput("n12_p3_err_cnt", 32'(err_cnt_n), 32'd1);
    checkOutput("n12_err_any", 32'(err_any_n), 32'd1);

    // Out-of-range readback on the 12-port instance
    rd_sel12 = 4'd13;
    applyStimulus(16'h0000, 16'h0000, 1'b0);
    checkOutput("n12_sel13_frame_cnt", 32'(frame_cnt_n), 32'd0);
    checkOutput("n12_sel13_err_cnt", 32'(err_cnt_n), 32'd0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
